// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads a combinational instruction memory and queues {pc, instr} toward decode.
// Optional macro FETCH_PERF_CNT_EN adds fetch and stall performance counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        halt_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_adr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [31:0]      pc_q;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      buf_instr [FIFO_DEPTH];
  logic [31:0]      buf_pc    [FIFO_DEPTH];

  logic pop;
  logic push_ok;
  logic push;
  logic not_empty;

  assign not_empty     = (count != '0);
  assign instr_valid_o = not_empty;
  assign pop           = instr_valid_o & instr_ready_i;
  assign push_ok       = (count != FULL_CNT) | pop;
  assign push          = ~redirect_i & ~halt_i & push_ok;

  assign imem_adr_o = pc_q;
  assign instr_o    = not_empty ? buf_instr[rd_ptr] : 32'h0;
  assign instr_pc_o = not_empty ? buf_pc[rd_ptr]    : 32'h0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      // Flush beats any same-cycle pop and overrides halt.
      pc_q   <= {redirect_pc_i[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q   <= pc_q + 32'd4;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      buf_instr[wr_ptr] <= imem_rdata_i;
      buf_pc[wr_ptr]    <= pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_fetch_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (push) begin
        perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      end
      if (~halt_i & ~redirect_i & ~push_ok) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fill, streaming, redirect, halt, PC wrap and mid-run reset.
// Counter checks are compiled in only when FETCH_PERF_CNT_EN is defined.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_adr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .halt_i       (halt),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem_adr_o   (imem_adr),
    .imem_rdata_i (imem_rdata),
    .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready),
    .instr_o      (instr),
    .instr_pc_o   (instr_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o(perf_fetch_cnt),
    .perf_stall_cnt_o(perf_stall_cnt)
`endif
  );

  // ROM: word w holds (w+1)*0x11, so addresses 0..0x10 hold 0x11..0x55.
  function automatic logic [31:0] rom(input logic [31:0] adr);
    return ((adr >> 2) + 32'd1) * 32'h11;
  endfunction

  assign imem_rdata = rom(imem_adr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;

    tick();
    tick();
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_adr",   imem_adr, 32'h0);
    check("rst_instr", instr,    32'h0);
    check("rst_pc",    instr_pc, 32'h0);

    // Fill with decode stalled
    rst_n = 1'b1;
    tick();
    check("fill1_valid", {31'b0, instr_valid}, 32'h1);
    check("fill1_adr",   imem_adr, 32'h4);
    check("fill1_instr", instr,    32'h11);
    tick();
    tick();
    tick();
    check("fill4_adr",   imem_adr, 32'h10);
    check("fill4_instr", instr,    32'h11);
    check("fill4_pc",    instr_pc, 32'h0);
    tick();
    check("full_stall_adr",   imem_adr, 32'h10);
    check("full_stall_instr", instr,    32'h11);
    check("full_stall_pc",    instr_pc, 32'h0);

    // Mid-run reset while full, then stream with ready held high
    rst_n = 1'b0;
    tick();
    check("midrst_valid", {31'b0, instr_valid}, 32'h0);
    check("midrst_adr",   imem_adr, 32'h0);
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stream_valid", {31'b0, instr_valid}, 32'h1);
      check("stream_pc",    instr_pc, 32'(4 * i));
      check("stream_instr", instr,    rom(32'(4 * i)));
    end

    // Redirect with PCs 0x8,0xC buffered and decode ready
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h8;
    tick();
    check("redir_a_valid", {31'b0, instr_valid}, 32'h0);
    check("redir_a_adr",   imem_adr, 32'h8);
    redirect = 1'b0;
    tick();
    tick();
    check("redir_setup_pc",  instr_pc, 32'h8);
    check("redir_setup_adr", imem_adr, 32'h10);
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    instr_ready = 1'b1;
    tick();
    check("redir_flush_valid", {31'b0, instr_valid}, 32'h0);
    check("redir_flush_adr",   imem_adr, 32'h40);
    redirect = 1'b0;
    tick();
    check("redir_tgt_valid", {31'b0, instr_valid}, 32'h1);
    check("redir_tgt_pc",    instr_pc, 32'h40);
    check("redir_tgt_instr", instr,    rom(32'h40));
    tick();
    check("redir_next_pc", instr_pc, 32'h44);

    // Halt with two entries buffered
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    check("halt_setup_pc", instr_pc, 32'h100);
    halt        = 1'b1;
    instr_ready = 1'b1;
    tick();
    check("halt_d1_pc",  instr_pc, 32'h104);
    check("halt_d1_adr", imem_adr, 32'h108);
    tick();
    check("halt_d2_valid", {31'b0, instr_valid}, 32'h0);
    check("halt_d2_adr",   imem_adr, 32'h108);
    tick();
    check("halt_d3_valid", {31'b0, instr_valid}, 32'h0);
    check("halt_d3_adr",   imem_adr, 32'h108);
    halt = 1'b0;
    tick();
    check("halt_resume_valid", {31'b0, instr_valid}, 32'h1);
    check("halt_resume_pc",    instr_pc, 32'h108);
    check("halt_resume_adr",   imem_adr, 32'h10C);

    // Redirect during halt to the top of memory, then PC wraps
    instr_ready = 1'b0;
    halt        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    check("wrap_redir_adr",   imem_adr, 32'hFFFF_FFFC);
    check("wrap_redir_valid", {31'b0, instr_valid}, 32'h0);
    redirect = 1'b0;
    halt     = 1'b0;
    tick();
    check("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_adr0",    imem_adr, 32'h0);
    tick();
    check("wrap_adr4",     imem_adr, 32'h4);
    check("wrap_hold_pc",  instr_pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    tick();
    check("wrap_second_pc",    instr_pc, 32'h0);
    check("wrap_second_instr", instr,    32'h11);

    // Fill, reset while full, refill and stall three cycles
    instr_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("rst2_valid", {31'b0, instr_valid}, 32'h0);
    check("rst2_adr",   imem_adr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst2_fetch_cnt", perf_fetch_cnt, 32'h0);
    check("rst2_stall_cnt", perf_stall_cnt, 32'h0);
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("stall_adr", imem_adr, 32'h10);
    check("stall_pc",  instr_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt", perf_stall_cnt, 32'd3);
    check("fetch_cnt", perf_fetch_cnt, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that owns the program counter.
- Drives the word address into the combinational instruction memory and captures the returned instruction word, tagged with its PC.
- Buffers fetched words in a small FIFO toward decode, using a valid/ready handshake.
- Supports redirect (jump/branch/trap target), which flushes the buffer, and halt, which stops new fetches.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 4: fetch buffer entries; power of two, >= 2.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- halt_i  input  1  when high, no new fetch is written; the buffer still drains.
- redirect_i  input  1  one-cycle pulse: flush the buffer and load a new PC.
- redirect_pc_i  input  32  redirect target; bits [1:0] are ignored (forced to 0).
- imem_adr_o  output  32  fetch address to instruction memory; equals pc_q.
- imem_rdata_i  input  32  instruction word, combinational from imem_adr_o in the same cycle.
- instr_valid_o  output  1  buffer head is valid.
- instr_ready_i  input  1  decode accepts the head this cycle.
- instr_o  output  32  head instruction word.
- instr_pc_o  output  32  PC of the head instruction.

Behaviour:
- Reset (rst_ni=0 at clock edge):
  - pc_q <= RESET_PC.
  - Buffer count, read pointer and write pointer <= 0.
  - instr_valid_o=0; instr_o and instr_pc_o read 0 while count==0.
  - Reset applied mid-operation discards all buffered words.
- Definitions:
  - pop = instr_valid_o & instr_ready_i.
  - push_ok = (count < FIFO_DEPTH) | pop.
- Priority per cycle, highest first:
  1. redirect_i=1:
     - count <= 0 and both pointers <= 0.
     - pc_q <= {redirect_pc_i[31:2],2'b00}.
     - No push; any pop in the same cycle is discarded (flush wins).
     - Applies even if halt_i=1.
  2. halt_i=1: no push, pc_q holds; pop proceeds normally.
  3. push_ok=1:
     - Write {pc_q, imem_rdata_i} at the write pointer.
     - pc_q <= pc_q + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  4. Otherwise (full, no pop): stall; pc_q holds and imem_adr_o is stable.
- Simultaneous push and pop when full: both occur, count unchanged.
- Push and pop on an empty buffer: not possible, since pop requires count>0.
- Latency:
  - Word fetched at PC p in cycle N appears at the head in cycle N+1 if the buffer was empty.
  - After a redirect in cycle N, the target instruction is valid in cycle N+2.
- Output ordering: strictly program order since the last redirect; no word from before a redirect is ever presented after it.
- Head outputs (instr_o, instr_pc_o) are stable while instr_valid_o=1 and instr_ready_i=0.
- Pointers wrap modulo FIFO_DEPTH; count range is 0..FIFO_DEPTH.
- No misalignment exception is raised; alignment is forced by masking bits [1:0].

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_fetch_cnt_o[31:0]: increments on every push.
  - perf_stall_cnt_o[31:0]: increments on every cycle with halt_i=0, redirect_i=0, push_ok=0.
  - Both reset to 0 and wrap at 2^32.
- When not defined:
  - Both ports and their counters are absent.
  - Behaviour is otherwise identical.

Test Plan:
- Fill: reset release, instr_ready_i=0, ROM words 0x11,0x22,0x33,0x44,0x55 at word addresses 0..4 -> after 4 cycles count=4, imem_adr_o holds 0x10, head instr_o=0x11 with instr_pc_o=0x0; a 5th word is not written.
- Streaming: instr_ready_i=1 constantly -> instr_pc_o sequence 0x0,0x4,0x8,... one per cycle, starting the cycle after reset release.
- Redirect: buffer holding PCs 0x8,0xC, redirect_i=1 with redirect_pc_i=0x43 and instr_ready_i=1 -> next cycle instr_valid_o=0 and imem_adr_o=0x40; the cycle after, instr_pc_o=0x40; 0x8 is never accepted.
- Halt: halt_i=1 with 2 entries buffered and ready=1 -> drains in 2 cycles, then valid=0 and imem_adr_o frozen; releasing halt resumes at the next sequential PC.
- Wrap: redirect to 0xFFFF_FFFC -> the following pushes carry PCs 0xFFFF_FFFC then 0x0000_0000.
- Mid-op reset and counters (FETCH_PERF_CNT_EN):
  - Assert rst_ni=0 for one cycle while full -> valid=0, imem_adr_o=RESET_PC, both counters read 0.
  - Then 3 cycles with ready=0 after the buffer fills -> perf_stall_cnt_o=3.
